// File: rtl/ssm_word_distributor_if.sv
// Source, request/grant and status bundle for the
// substream word distributor.
interface ssm_word_distributor_if #(
  parameter int NUM_SSM = 4,
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                      flush;
  logic                      in_vld;
  logic                      in_rdy;
  logic [DATA_W-1:0]         in_data;
  logic [NUM_SSM-1:0]        req;
  logic [NUM_SSM-1:0]        gnt;
  logic [NUM_SSM*DATA_W-1:0] dout;
  logic [LW-1:0]             level;
  logic [CNT_W-1:0]          words_consumed;

  modport master (
    output flush, in_vld, in_data, req,
    input  in_rdy, gnt, dout, level, words_consumed
  );

  modport slave (
    input  flush, in_vld, in_data, req,
    output in_rdy, gnt, dout, level, words_consumed
  );
endinterface

// File: rtl/ssm_word_distributor.sv
// Circular codec-word buffer feeding N substream parsers,
// granting requesters in channel-index order each cycle.
module ssm_word_distributor #(
  parameter int NUM_SSM = 4,
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 8,
  parameter int ATOMIC  = 0,
  parameter int CNT_W   = 32
) (
  input logic                   clk,
  input logic                   rst,
  ssm_word_distributor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [LW-1:0]     level;
  logic [CNT_W-1:0]  consumed;

  logic [LW-1:0]     rank [NUM_SSM];
  logic [LW-1:0]     n_req;
  logic [LW-1:0]     n_pop;
  logic [NUM_SSM-1:0] gnt;
  logic [NUM_SSM*DATA_W-1:0] dout;
  logic              full;
  logic              in_rdy;
  logic              push;

  assign full   = (level == LW'(DEPTH));
  // Not ready while reset or flush is clearing the buffer
  assign in_rdy = ~rst & ~bus.flush & ~full;
  assign push   = bus.in_vld & in_rdy;

  always_comb begin
    n_req = '0;
    for (int i = 0; i < NUM_SSM; i++) begin
      rank[i] = n_req;
      n_req   = n_req + LW'(bus.req[i]);
    end
  end

  always_comb begin
    gnt   = '0;
    n_pop = '0;
    dout  = '0;
    for (int i = 0; i < NUM_SSM; i++) begin
      if (ATOMIC != 0)
        gnt[i] = bus.req[i] & (n_req <= level);
      else
        gnt[i] = bus.req[i] & (rank[i] < level);
      gnt[i] = gnt[i] & ~rst & ~bus.flush;
      n_pop  = n_pop + LW'(gnt[i]);
      dout[i*DATA_W +: DATA_W] =
        mem[rd_ptr + rank[i][AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      consumed <= '0;
    end else begin
      rd_ptr   <= rd_ptr + n_pop[AW-1:0];
      wr_ptr   <= wr_ptr + AW'(push);
      level    <= level + LW'(push) - n_pop;
      consumed <= consumed + CNT_W'(n_pop);
    end
  end

  assign bus.in_rdy         = in_rdy;
  assign bus.gnt            = gnt;
  assign bus.dout           = dout;
  assign bus.level          = level;
  assign bus.words_consumed = consumed;
endmodule

// File: doc/ssm_word_distributor.md
Name: ssm_word_distributor

Overview:
- Synthesizable N-channel distributor of 128-bit codec words from one shared bitstream buffer to the substream parsers (bitparse / bitparse_ssm123).
- Replaces the bench-side address-advance and prefix-select logic with a circular word buffer and a request/grant handshake.
- Serves any subset of requesters in one cycle, ranked by channel index.
- Adds partial or atomic grant modes, flush, and backpressure to the bitstream source.

Parameters:
NUM_SSM, 4, number of substream channels (1..8)
DATA_W, 128, codec word width in bits
DEPTH, 8, buffer depth in words; power of 2, DEPTH >= NUM_SSM
ATOMIC, 0, 0 = partial grant in index order; 1 = grant all requests or none
CNT_W, 32, width of the consumed-word counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous buffer clear (slice start)
in_vld  in  1  source word valid
in_rdy  out  1  buffer can accept a word
in_data  in  DATA_W  source codec word
req  in  NUM_SSM  per-channel word request (level)
gnt  out  NUM_SSM  per-channel grant, same cycle as req
dout  out  NUM_SSM*DATA_W  channel i data on bits [i*DATA_W +: DATA_W], valid when gnt[i]
level  out  log2(DEPTH)+1  words currently buffered
words_consumed  out  CNT_W  total words granted since reset/flush

Behaviour:
- State: storage array mem[DEPTH], rd_ptr and wr_ptr (log2(DEPTH) bits, wrap modulo DEPTH), level, words_consumed.
- Reset (rst=1 at posedge): rd_ptr=wr_ptr=0, level=0, words_consumed=0. Mem contents are don't-care.
- Outputs under reset: in_rdy=0 in the reset cycle and 1 afterwards; gnt=0 while level=0.
- Rank and grant (combinational):
  - rank[i] = popcount(req[i-1:0]).
  - ATOMIC=0: gnt[i] = req[i] & (rank[i] < level).
  - ATOMIC=1: gnt[i] = req[i] & (popcount(req) <= level).
  - Never grant beyond level. Grants are a prefix of the set requests ordered by index.
- Data: dout[i] = mem[(rd_ptr + rank[i]) mod DEPTH]. This is zero-latency: the parser samples the data on the cycle gnt is high. When gnt[i]=0, dout[i] is don't-care.
- Pop: n_pop = popcount(gnt). At the clock edge, rd_ptr += n_pop (wraps) and words_consumed += n_pop (wraps at 2^CNT_W).
- Push:
  - in_rdy = (level < DEPTH), registered-equivalent (a function of state only, no dependency on req).
  - push = in_vld & in_rdy. On push, mem[wr_ptr] <= in_data and wr_ptr++.
- Level update: level <= level + push - n_pop. Push and pop in the same cycle are allowed.
- Same-cycle write/read: a word pushed this cycle is not grantable until the next cycle (no bypass). At level=0, all gnt=0 even if in_vld=1.
- Full: at level=DEPTH, in_rdy=0. A pop in that cycle does not raise in_rdy until the next cycle.
- Ungranted requesters keep req high. They are served in later cycles, again in index order.
- Flush:
  - Takes effect at the edge and overrides push/pop in the same cycle.
  - Result: rd_ptr=wr_ptr=0, level=0, words_consumed=0.
  - gnt is forced to 0 combinationally during the flush cycle.
- Reset mid-operation: all state clears next edge regardless of req or in_vld. No partial grant completes.
- Requester contract: req may deassert any cycle. gnt is meaningful only in the cycle it is high.

Test Plan:
- Reset, then push 8 words W0..W7 (in_vld=1 for 8 cycles) -> level=8, in_rdy=0; a 9th in_vld=1 is not accepted.
- With level=8, req=4'b1111 for one cycle -> gnt=1111, dout0..3=W0..W3; next cycle level=4, words_consumed=4; req=4'b1010 -> ch1=W4, ch3=W5.
- level=2, ATOMIC=0, req=4'b1111 -> gnt=0011, ch0/ch1 get the next two words. ATOMIC=1 with the same stimulus -> gnt=0000 and level stays 2.
- Wrap: DEPTH=8 with rd_ptr=6 and level=4 (words W6,W7,W8,W9), req=4'b1111 -> data in order W6,W7,W8,W9; rd_ptr=2 afterwards.
- Full buffer with simultaneous push and req=4'b0001 -> push rejected (in_rdy=0), one pop; next cycle in_rdy=1 and level=7.
- flush=1 together with req=4'b1111 and in_vld=1 -> gnt=0000; next cycle level=0, words_consumed=0, in_rdy=1. A mid-stream rst=1 gives the identical cleared state.
